// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared word format, opcode field and fetch action encoding
package fetch_ctrl_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 13;
   localparam int unsigned OP_W   = OP_HI - OP_LO + 1;

   localparam logic [WORD_W-1:0] PKG_NOP_WORD = 16'h0000;
   localparam logic [OP_W-1:0]   PKG_BEQ_OP   = 3'd2;

   // Winning per-edge action, listed lowest to highest priority
   typedef enum logic [2:0] {
      ACT_ADV,
      ACT_HOLD,
      ACT_STALL,
      ACT_TAKEN,
      ACT_MP
   } fetch_act_e;

   function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
      return word[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/rec_fifo.sv
// rtl/rec_fifo.sv - two-entry recovery queue of fall-through PCs for in-flight branches
module rec_fifo
   import fetch_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              clear_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [WORD_W-1:0] head_o,
   output logic [1:0]        count_o
);

   logic [WORD_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              pop_ok;
   logic              push_ok;

   // When full, a push is only legal if the head leaves in the same edge
   assign pop_ok  = pop_i && (count_q != 2'd0);
   assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (clear_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch: PC, IF/ID register, branch recovery and redirect
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
   parameter logic [WORD_W-1:0] NOP_WORD = PKG_NOP_WORD,
   parameter logic [OP_W-1:0]   BEQ_OP   = PKG_BEQ_OP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] Instr,
   input  logic              PCStall,
   input  logic              MP,
   input  logic              PCSrc,
   input  logic [WORD_W-1:0] BranchTarget,
   input  logic              BrResolve,
   output logic [WORD_W-1:0] PC,
   output logic [WORD_W-1:0] IFID,
   output logic [WORD_W-1:0] IFIDPC,
   output logic              Flush,
   output logic              FetchHold,
   output logic [1:0]        RecCount,
   output logic              RecErr
);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] ifid_q, ifid_d;
   logic [WORD_W-1:0] ifidpc_q, ifidpc_d;
   logic              err_q, err_d;

   logic [WORD_W-1:0] pc_plus1;
   logic [WORD_W-1:0] rec_head;
   logic [1:0]        rec_count;
   logic              rec_empty;
   logic              is_beq;
   logic              taken;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clear;
   fetch_act_e        act;

   assign pc_plus1  = pc_q + 16'd1;
   assign is_beq    = (opcode_of(Instr) == BEQ_OP);
   assign taken     = PCSrc & BrResolve;
   assign rec_empty = (rec_count == 2'd0);

   assign Flush     = MP | taken;
   assign FetchHold = (rec_count == 2'd2) && is_beq && !BrResolve;

   always_comb begin
      if (MP)             act = ACT_MP;
      else if (taken)     act = ACT_TAKEN;
      else if (PCStall)   act = ACT_STALL;
      else if (FetchHold) act = ACT_HOLD;
      else                act = ACT_ADV;
   end

   always_comb begin
      pc_d       = pc_q;
      ifid_d     = ifid_q;
      ifidpc_d   = ifidpc_q;
      err_d      = err_q | ((BrResolve | MP) & rec_empty);
      fifo_push  = 1'b0;
      fifo_pop   = BrResolve & ~MP;
      fifo_clear = MP;

      case (act)
         ACT_MP: begin
            // An MP with nothing outstanding has no recovery point; restart from reset
            pc_d     = rec_empty ? RESET_PC : rec_head;
            ifid_d   = NOP_WORD;
            ifidpc_d = '0;
         end
         ACT_TAKEN: begin
            pc_d     = BranchTarget;
            ifid_d   = NOP_WORD;
            ifidpc_d = '0;
         end
         ACT_ADV: begin
            pc_d      = pc_plus1;
            ifid_d    = Instr;
            ifidpc_d  = pc_plus1;
            fifo_push = is_beq;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ifid_q   <= NOP_WORD;
         ifidpc_q <= '0;
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ifid_q   <= ifid_d;
         ifidpc_q <= ifidpc_d;
         err_q    <= err_d;
      end
   end

   rec_fifo u_rec_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .clear_i (fifo_clear),
      .data_i  (pc_plus1),
      .head_o  (rec_head),
      .count_o (rec_count)
   );

   assign PC       = pc_q;
   assign IFID     = ifid_q;
   assign IFIDPC   = ifidpc_q;
   assign RecCount = rec_count;
   assign RecErr   = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clock;
   logic        reset;
   logic [15:0] Instr;
   logic        PCStall;
   logic        MP;
   logic        PCSrc;
   logic [15:0] BranchTarget;
   logic        BrResolve;
   logic [15:0] PC;
   logic [15:0] IFID;
   logic [15:0] IFIDPC;
   logic        Flush;
   logic        FetchHold;
   logic [1:0]  RecCount;
   logic        RecErr;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ifid;
      logic [15:0] ifidpc;
      logic [1:0]  cnt;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [15:0] N = 16'h1234;
   localparam logic [15:0] B = 16'h4000;

   fetch_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .Instr        (Instr),
      .PCStall      (PCStall),
      .MP           (MP),
      .PCSrc        (PCSrc),
      .BranchTarget (BranchTarget),
      .BrResolve    (BrResolve),
      .PC           (PC),
      .IFID         (IFID),
      .IFIDPC       (IFIDPC),
      .Flush        (Flush),
      .FetchHold    (FetchHold),
      .RecCount     (RecCount),
      .RecErr       (RecErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_state(input string tag, input exp_t e);
      chk({tag, ".pc"},     PC,              e.pc);
      chk({tag, ".ifid"},   IFID,            e.ifid);
      chk({tag, ".ifidpc"}, IFIDPC,          e.ifidpc);
      chk({tag, ".cnt"},    16'(RecCount),   16'(e.cnt));
      chk({tag, ".err"},    16'(RecErr),     16'(e.err));
   endtask

   task automatic cyc(input string tag, input logic [15:0] ins,
                      input logic stl, input logic mp, input logic src, input logic brr,
                      input logic [15:0] tgt, input logic e_fl, input logic e_fh,
                      input logic [15:0] e_pc, input logic [15:0] e_ifid,
                      input logic [15:0] e_ifidpc, input logic [1:0] e_cnt, input logic e_err);
      exp_t e;
      @(negedge clock);
      Instr        = ins;
      PCStall      = stl;
      MP           = mp;
      PCSrc        = src;
      BrResolve    = brr;
      BranchTarget = tgt;
      #1;
      chk({tag, ".flush"}, 16'(Flush),     16'(e_fl));
      chk({tag, ".hold"},  16'(FetchHold), 16'(e_fh));
      sb.push_back('{pc: e_pc, ifid: e_ifid, ifidpc: e_ifidpc, cnt: e_cnt, err: e_err});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk_state(tag, e);
   endtask

   initial begin
      reset = 1'b1; Instr = 16'h0000; PCStall = 1'b1; MP = 1'b0;
      PCSrc = 1'b0; BranchTarget = 16'h0000; BrResolve = 1'b0;
      #3;
      chk_state("reset", '{pc: 16'h0000, ifid: 16'h0000, ifidpc: 16'h0000, cnt: 2'd0, err: 1'b0});
      chk("reset.flush", 16'(Flush), 16'h0000);
      @(negedge clock);
      reset = 1'b0;

      //   tag       Instr stl mp src brr target   fl fh  PC       IFID     IFIDPC   cnt err
      cyc("adv1",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0001, N,       16'h0001, 0, 0);
      cyc("adv2",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0002, N,       16'h0002, 0, 0);
      cyc("adv3",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0003, N,       16'h0003, 0, 0);
      cyc("adv4",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0004, N,       16'h0004, 0, 0);
      cyc("adv5",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0005, N,       16'h0005, 0, 0);
      cyc("beq5",    B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0006, B,       16'h0006, 1, 0);
      cyc("taken20", N,    0,  0, 1,  1,  16'h20,  1, 0,  16'h0020, 16'h0,   16'h0000, 0, 0);
      cyc("redir",   N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0021, N,       16'h0021, 0, 0);
      cyc("beq21",   B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0022, B,       16'h0022, 1, 0);
      cyc("taken8",  N,    0,  0, 1,  1,  16'h8,   1, 0,  16'h0008, 16'h0,   16'h0000, 0, 0);
      cyc("beq8",    B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0009, B,       16'h0009, 1, 0);
      cyc("adv9",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h000A, N,       16'h000A, 1, 0);
      cyc("mp9",     N,    0,  1, 0,  1,  16'h0,   1, 0,  16'h0009, 16'h0,   16'h0000, 0, 0);
      cyc("beqA",    B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h000A, B,       16'h000A, 1, 0);
      cyc("beqB",    B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h000B, B,       16'h000B, 2, 0);
      cyc("hold1",   B,    0,  0, 0,  0,  16'h0,   0, 1,  16'h000B, B,       16'h000B, 2, 0);
      cyc("hold2",   B,    0,  0, 0,  0,  16'h0,   0, 1,  16'h000B, B,       16'h000B, 2, 0);
      cyc("pushpop", B,    0,  0, 0,  1,  16'h0,   0, 0,  16'h000C, B,       16'h000C, 2, 0);
      cyc("tk100",   N,    0,  0, 1,  1,  16'h100, 1, 0,  16'h0100, 16'h0,   16'h0000, 1, 0);
      cyc("mpC",     N,    0,  1, 0,  0,  16'h0,   1, 0,  16'h000C, 16'h0,   16'h0000, 0, 0);
      cyc("err1",    N,    0,  0, 0,  1,  16'h0,   0, 0,  16'h000D, N,       16'h000D, 0, 1);
      cyc("err2",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h000E, N,       16'h000E, 0, 1);
      cyc("mpempty", N,    0,  1, 0,  0,  16'h0,   1, 0,  16'h0000, 16'h0,   16'h0000, 0, 1);
      cyc("beq0",    B,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0001, B,       16'h0001, 1, 1);
      cyc("tkFFFF",  N,    0,  0, 1,  1,  16'hFFFF,1, 0,  16'hFFFF, 16'h0,   16'h0000, 0, 1);
      cyc("stall1",  N,    1,  0, 0,  0,  16'h0,   0, 0,  16'hFFFF, 16'h0,   16'h0000, 0, 1);
      cyc("stall2",  N,    1,  0, 0,  0,  16'h0,   0, 0,  16'hFFFF, 16'h0,   16'h0000, 0, 1);
      cyc("wrap",    N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0000, N,       16'h0000, 0, 1);
      cyc("postwrap",N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0001, N,       16'h0001, 0, 1);
      cyc("stall3",  N,    1,  0, 0,  0,  16'h0,   0, 0,  16'h0001, N,       16'h0001, 0, 1);

      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk_state("midreset", '{pc: 16'h0000, ifid: 16'h0000, ifidpc: 16'h0000, cnt: 2'd0, err: 1'b0});
      @(negedge clock);
      reset = 1'b0;

      cyc("rstadv",  N,    0,  0, 0,  0,  16'h0,   0, 0,  16'h0001, N,       16'h0001, 0, 0);

      chk("sb.empty", 16'(sb.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 16'h0000, word inserted into IFID on flush.
REQ-003 Parameter BEQ_OP, default 3'd2, opcode (bits 15:13) identifying a branch.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 Instr  input  16  instruction-memory word at address PC.
REQ-007 PCStall  input  1  hazard stall request; holds PC and IFID.
REQ-008 MP  input  1  misprediction pulse from hazard control.
REQ-009 PCSrc  input  1  branch-taken indication from EX stage.
REQ-010 BranchTarget  input  16  taken-branch target address.
REQ-011 BrResolve  input  1  one-cycle pulse when EX evaluates a BEQ.
REQ-012 PC  output  16  current fetch address (registered).
REQ-013 IFID  output  16  IF/ID instruction register.
REQ-014 IFIDPC  output  16  PC+1 of the instruction held in IFID.
REQ-015 Flush  output  1  combinational, MP | (PCSrc & BrResolve).
REQ-016 FetchHold  output  1  combinational, high when fetch is held for a full recovery queue.
REQ-017 RecCount  output  2  recovery-queue occupancy (0..2).
REQ-018 RecErr  output  1  sticky error flag.

Function
REQ-019 Per-edge priority SHALL be: reset > MP > taken (PCSrc & BrResolve) > PCStall > FetchHold > advance.
REQ-020 MP: PC <= head of recovery queue; IFID <= NOP_WORD; IFIDPC <= 0; queue cleared to empty.
REQ-021 Taken: PC <= BranchTarget; IFID <= NOP_WORD; IFIDPC <= 0; queue pops one entry.
REQ-022 PCStall: PC, IFID and IFIDPC hold; a BrResolve pop still takes effect.
REQ-023 FetchHold SHALL be high when RecCount==2 and Instr[15:13]==BEQ_OP and no BrResolve occurs in the same cycle; in that state PC and IFID hold.
REQ-024 Advance: PC <= PC+1 (mod 2^16, 16'hFFFF wraps to 16'h0000); IFID <= Instr; IFIDPC <= PC+1.
REQ-025 Push: on advance with Instr[15:13]==BEQ_OP, PC+1 SHALL be pushed to the recovery-queue tail.
REQ-026 Pop: BrResolve without MP SHALL pop the head; a simultaneous push and pop leaves RecCount unchanged and the pushed entry becomes the new tail.
REQ-027 Queue: 2-entry FIFO with 1-bit pointers and wrap-around.
REQ-028 BrResolve or MP with RecCount==0 SHALL set RecErr; in that case the queue is unchanged and an MP redirect uses RESET_PC.
REQ-029 RecErr SHALL remain set until reset.
REQ-030 Redirect latency: PC shows the new address on the edge after MP or taken; the first redirected instruction reaches IFID one edge later.
REQ-031 The redirected (wrong-path) fetch SHALL NOT push to the queue in the redirect cycle.

Reset
REQ-032 On reset assertion: PC=RESET_PC, IFID=NOP_WORD, IFIDPC=0, RecCount=0, queue pointers=0, RecErr=0, independent of clock.
REQ-033 Reset asserted mid-redirect or mid-stall SHALL abandon that operation; the first advance after release fetches RESET_PC.

Structure
REQ-034 NOP_WORD, BEQ_OP, the opcode field position (15:13) and the 16-bit word width SHALL live in a shared package used by the hazard and decode blocks.
REQ-035 The recovery queue SHALL be a sub-module named rec_fifo (push, pop, clear, head, count).

Verification
REQ-036 Reset, then 3 advances with Instr=16'h1234 -> PC=3, IFID=16'h1234, IFIDPC=3, Flush=0.
REQ-037 BEQ (16'h4000) fetched at PC=5, then BrResolve+PCSrc with BranchTarget=16'h0020 -> Flush=1 that cycle; PC=16'h0020 next edge; IFID=NOP; RecCount 1->0.
REQ-038 BEQ fetched at PC=8, then MP+BrResolve with PCSrc=0 -> PC=9 next edge; IFID=NOP; RecCount=0.
REQ-039 Two BEQs queued, third BEQ on Instr -> FetchHold=1 and PC holds; on BrResolve the third BEQ is pushed and RecCount stays 2.
REQ-040 PCStall=1 for 2 cycles at PC=16'hFFFF, then release -> PC holds 16'hFFFF, then wraps to 16'h0000.
REQ-041 BrResolve with empty queue -> RecErr=1 and stays 1; PC advances normally.
